// File: rtl/spike_merge_fifo.sv
// ----------------------------------------------------------------------------
// spike_merge_fifo: round-robin merge of spike channels into one circular FIFO
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module spike_merge_fifo #(
  parameter int NEURON_ID_W  = 4,
  parameter int NUM_CH       = 4,
  parameter int DEPTH        = 16,
  parameter int DROP_ON_FULL = 0,
  parameter int CNT_W        = 8,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LVL_W       = $clog2(DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             spike_in,
  input  logic [NUM_CH*NEURON_ID_W-1:0] spike_id_in,
  output logic [NUM_CH-1:0]             spike_ready,
  output logic                          spike_valid,
  output logic [CH_W-1:0]               spike_ch_out,
  output logic [NEURON_ID_W-1:0]        spike_id_out,
  input  logic                          spike_accept,
  output logic [LVL_W-1:0]              level,
  output logic [CNT_W-1:0]              drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = CH_W + NEURON_ID_W;
  localparam int POP_W = CH_W + 1;
  localparam int SUM_W = CNT_W + POP_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [ENT_W-1:0] mem_q [DEPTH];

  logic             full, empty, any_req, wr_en, pop_en;
  logic [CH_W-1:0]  grant_ch;
  logic [NUM_CH-1:0] ready_raw;
  logic [POP_W-1:0] drop_inc;
  logic [SUM_W-1:0] drop_sum;

  function automatic logic [CH_W-1:0] wrap_ch(input logic [CH_W-1:0] base, input int off);
    int unsigned s;
    s = 32'(base) + 32'(off);
    return CH_W'(s % NUM_CH);
  endfunction

  // First requester at or after rr_ptr, scanning modulo NUM_CH.
  always_comb begin
    any_req  = 1'b0;
    grant_ch = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!any_req && spike_in[wrap_ch(rr_ptr_q, i)]) begin
        any_req  = 1'b1;
        grant_ch = wrap_ch(rr_ptr_q, i);
      end
    end
  end

  assign full   = (level_q == LVL_W'(DEPTH));
  assign empty  = (level_q == '0);
  assign wr_en  = any_req & ~full;
  assign pop_en = ~empty & spike_accept;

  generate
    if (DROP_ON_FULL != 0) begin : g_lossy
      logic [POP_W-1:0] req_cnt;
      always_comb begin
        req_cnt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
          req_cnt = req_cnt + POP_W'(spike_in[c]);
        end
      end
      assign ready_raw = '1;
      // Every requester except the one written this cycle is lost.
      assign drop_inc  = req_cnt - POP_W'(wr_en);
    end else begin : g_backpressure
      logic [NUM_CH-1:0] grant;
      always_comb begin
        grant           = '0;
        grant[grant_ch] = any_req;
      end
      assign ready_raw = grant & {NUM_CH{~full}};
      assign drop_inc  = '0;
    end
  endgenerate

  assign spike_ready = rst ? '0 : ready_raw;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rr_ptr_d = rr_ptr_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      rr_ptr_d = (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + CH_W'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  assign level_d  = level_q + LVL_W'(wr_en) - LVL_W'(pop_en);
  assign drop_sum = SUM_W'(drop_q) + SUM_W'(drop_inc);
  assign drop_d   = (drop_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : drop_sum[CNT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rr_ptr_q <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      rr_ptr_q <= rr_ptr_d;
      drop_q   <= drop_d;
    end
  end

  // Storage is left unreset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {grant_ch, spike_id_in[grant_ch*NEURON_ID_W +: NEURON_ID_W]};
    end
  end

  assign {spike_ch_out, spike_id_out} = mem_q[rd_ptr_q];
  assign spike_valid = ~empty;
  assign level       = level_q;
  assign drop_count  = drop_q;

endmodule

`default_nettype wire
